// File: rtl/mux_pkg.sv
// Shared types and defaults for the registered N-to-1 stream multiplexer.
package mux_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} mux_state_e;
  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_e;

  localparam int MUX_W_DEF   = 32;
  localparam int MUX_NCH_DEF = 4;
endpackage

// File: rtl/mux_n_to_1_stream_rr_arbiter.sv
// Round-robin arbiter: lowest-index request at or after ptr wins; ptr moves past the winner on advance.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH = MUX_NCH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          req,
  input  logic                    advance,
  output logic [$clog2(NCH)-1:0]  grant,
  output logic                    grant_valid
);
  localparam int SELW = $clog2(NCH);

  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] w_idx;

  // Scan backwards so the candidate closest to ptr is written last and wins.
  always_comb begin
    grant = '0;
    w_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_idx = SELW'((int'(r_ptr) + k) % NCH);
      if (req[w_idx]) begin
        grant = w_idx;
      end
    end
  end

  assign grant_valid = |req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (advance && grant_valid) begin
      r_ptr <= (grant == SELW'(NCH - 1)) ? '0 : grant + 1'b1;
    end
  end
endmodule

// File: rtl/mux_n_to_1_stream.sv
// Registered N-to-1 stream mux with a one-entry output register; in_ready follows out_ready combinationally.
// Define MUX_RR_EN to build the round-robin arbiter and honour rr_mode; otherwise selection is always by sel.
module mux_n_to_1_stream
  import mux_pkg::*;
#(
  parameter int W    = MUX_W_DEF,
  parameter int NCH  = MUX_NCH_DEF,
  parameter int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SELW-1:0]   sel,
  input  logic              rr_mode,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready
);
  mux_state_e      r_state;
  mux_state_e      w_state_nxt;
  logic [W-1:0]    r_data;
  logic [SELW-1:0] r_ch;

  mux_mode_e       w_mode;
  logic [SELW-1:0] w_fix_grant;
  logic            w_fix_valid;
  logic [SELW-1:0] w_rr_grant;
  logic            w_rr_valid;
  logic [SELW-1:0] w_grant;
  logic            w_grant_valid;
  logic            w_load;
  logic [W-1:0]    w_grant_data;

  // An out-of-range select grants nothing.
  assign w_fix_grant = sel;
  assign w_fix_valid = (int'(sel) < NCH) && in_valid[sel];

`ifdef MUX_RR_EN
  assign w_mode = rr_mode ? MODE_RR : MODE_FIXED;

  rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .req         (in_valid),
    .advance     (w_load && (w_mode == MODE_RR)),
    .grant       (w_rr_grant),
    .grant_valid (w_rr_valid)
  );
`else
  // rr_mode stays on the port list but is masked off without the arbiter.
  assign w_mode     = (rr_mode & 1'b0) ? MODE_RR : MODE_FIXED;
  assign w_rr_grant = w_fix_grant;
  assign w_rr_valid = w_fix_valid;
`endif

  assign w_grant       = (w_mode == MODE_RR) ? w_rr_grant : w_fix_grant;
  assign w_grant_valid = (w_mode == MODE_RR) ? w_rr_valid : w_fix_valid;
  assign w_load        = reset && w_grant_valid && (!out_valid || out_ready);

  always_comb begin
    in_ready     = '0;
    w_grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant == SELW'(i)) begin
        in_ready[i]  = w_load;
        w_grant_data = in_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_load) w_state_nxt = FULL;
      FULL:    if (out_ready && !w_load) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
      r_ch   <= '0;
    end else if (w_load) begin
      r_data <= w_grant_data;
      r_ch   <= w_grant;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_ch    = r_ch;
endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Scoreboard bench: stimulus queues hand-computed words, a negedge monitor pops on every output handshake.
module tb_mux_n_to_1_stream;
  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  ch;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [1:0]   sel;
  logic         rr_mode;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic         out_valid;
  logic         out_ready;

  logic [1:0]   sel3;
  logic         rr_mode3;
  logic [95:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_ch3;
  logic         out_valid3;
  logic         out_ready3;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  mux_n_to_1_stream #(.W(32), .NCH(4)) u_dut (
    .clk(clk), .reset(reset), .sel(sel), .rr_mode(rr_mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_n_to_1_stream #(.W(32), .NCH(3)) u_dut3 (
    .clk(clk), .reset(reset), .sel(sel3), .rr_mode(rr_mode3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] ch);
    exp_t e;
    e.d  = d;
    e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic set_ch(input int i, input logic [31:0] d);
    in_data[i*32 +: 32] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got data %0h ch %0d, expected no word", out_data, out_ch);
      end else begin
        e = exp_q.pop_front();
        chk("mon_data", {32'h0, out_data}, {32'h0, e.d});
        chk("mon_ch", {62'h0, out_ch}, {62'h0, e.ch});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rdy_e;
    reset      = 1'b0;
    sel        = 2'd0;
    rr_mode    = 1'b0;
    in_valid   = 4'hF;
    in_data    = {32'h4, 32'h3, 32'h2, 32'h1};
    out_ready  = 1'b1;
    sel3       = 2'd0;
    rr_mode3   = 1'b0;
    in_valid3  = 3'b111;
    in_data3   = {32'h3, 32'h2, 32'h1};
    out_ready3 = 1'b1;

    // Reset held for two edges with everything valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_ch", 64'(out_ch), 64'h0);
    chk("rst_rdy", 64'(in_ready), 64'h0);
    chk("rst3_valid", 64'(out_valid3), 64'h0);
    step();
    reset     = 1'b1;
    in_valid  = 4'h0;
    in_valid3 = 3'b000;

    // Fixed select streaming on ch2.
    sel      = 2'd2;
    in_valid = 4'b0100;
    set_ch(2, 32'hA5A5_0001);
    push(32'hA5A5_0001, 2'd2);
    @(negedge clk);
    chk("str_rdy0", 64'(in_ready), 64'h4);
    chk("str_empty", 64'(out_valid), 64'h0);
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k < 3) begin
        set_ch(2, 32'hA5A5_0000 + 32'(k + 1));
        push(32'hA5A5_0000 + 32'(k + 1), 2'd2);
      end else begin
        in_valid = 4'h0;
      end
      @(negedge clk);
      chk("str_data", 64'(out_data), 64'hA5A5_0000 + 64'(k));
      chk("str_ch", 64'(out_ch), 64'h2);
      chk("str_valid", 64'(out_valid), 64'h1);
      if (k < 3) chk("str_rdy", 64'(in_ready), 64'h4);
    end
    step();
    @(negedge clk);
    chk("str_drain", 64'(out_valid), 64'h0);

    // Back-pressure with a second word waiting.
    step();
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    set_ch(2, 32'hDEAD_BEEF);
    push(32'hDEAD_BEEF, 2'd2);
    step();
    set_ch(2, 32'hCAFE_0001);
    push(32'hCAFE_0001, 2'd2);
    repeat (3) begin
      @(negedge clk);
      chk("bp_data", 64'(out_data), 64'hDEAD_BEEF);
      chk("bp_valid", 64'(out_valid), 64'h1);
      chk("bp_rdy", 64'(in_ready), 64'h0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 64'(in_ready), 64'h4);
    step();
    in_valid = 4'h0;
    @(negedge clk);
    chk("bp_next_data", 64'(out_data), 64'hCAFE_0001);
    step();
    @(negedge clk);
    chk("bp_drain", 64'(out_valid), 64'h0);

    // Out-of-range select on the 3-channel instance, then a legal one.
    step();
    sel3      = 2'd3;
    in_valid3 = 3'b111;
    repeat (3) begin
      @(negedge clk);
      chk("inv_rdy", 64'(in_ready3), 64'h0);
      chk("inv_valid", 64'(out_valid3), 64'h0);
      step();
    end
    sel3 = 2'd2;
    in_data3[64 +: 32] = 32'h3333_0002;
    @(negedge clk);
    chk("sel3_rdy", 64'(in_ready3), 64'h4);
    step();
    in_valid3 = 3'b000;
    @(negedge clk);
    chk("sel3_valid", 64'(out_valid3), 64'h1);
    chk("sel3_data", 64'(out_data3), 64'h3333_0002);
    chk("sel3_ch", 64'(out_ch3), 64'h2);
    step();

`ifdef MUX_RR_EN
    // Round-robin: strict rotation with all valid, then ch1/ch3 only from ptr=2.
    rr_mode  = 1'b1;
    in_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_ch(i, 32'h5000_0000 + 32'(i));
    push(32'h5000_0000, 2'd0);
    push(32'h5000_0001, 2'd1);
    push(32'h5000_0002, 2'd2);
    push(32'h5000_0003, 2'd3);
    push(32'h5000_0000, 2'd0);
    for (int k = 0; k < 5; k++) begin
      rdy_e = 4'b0001 << (k % 4);
      @(negedge clk);
      chk("rr_rot_rdy", 64'(in_ready), 64'(rdy_e));
      step();
    end
    in_valid = 4'b0010;
    push(32'h5000_0001, 2'd1);
    @(negedge clk);
    chk("rr_ptr_setup_rdy", 64'(in_ready), 64'h2);
    step();
    in_valid = 4'b1010;
    push(32'h5000_0003, 2'd3);
    push(32'h5000_0001, 2'd1);
    push(32'h5000_0003, 2'd3);
    for (int k = 0; k < 3; k++) begin
      rdy_e = (k == 1) ? 4'b0010 : 4'b1000;
      @(negedge clk);
      chk("rr_pair_rdy", 64'(in_ready), 64'(rdy_e));
      step();
    end
    in_valid = 4'h0;
`else
    // Without the arbiter rr_mode is ignored: sel alone decides.
    rr_mode  = 1'b1;
    sel      = 2'd1;
    in_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_ch(i, 32'h7000_0000 + 32'(i));
    push(32'h7000_0001, 2'd1);
    push(32'h7000_0001, 2'd1);
    push(32'h7000_0001, 2'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("norr_rdy", 64'(in_ready), 64'h2);
      step();
    end
    in_valid = 4'h0;
`endif

    for (int t = 0; t < 10 && exp_q.size() != 0; t++) step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
